// File: rtl/raifes_uart_pkg.sv
// rtl/raifes_uart_pkg.sv - shared constants, register map and FSM state type for raifes_uart
package raifes_uart_pkg;
  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam logic [31:0] UART_BASE   = 32'hC000_0000;
  localparam logic [1:0]  UART_DATA   = 2'd0;
  localparam logic [1:0]  UART_STATUS = 2'd1;
  localparam logic [1:0]  UART_DIV    = 2'd2;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_TX_BUSY    = 2;
  localparam int ST_RX_VALID   = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_TX_DROP    = 5;
  localparam int ST_FRAME_ERR  = 6;

  localparam logic [15:0] UART_MIN_DIV = 16'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // Very small divisors leave no room for the half-bit RX start check.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < UART_MIN_DIV) ? UART_MIN_DIV : v;
  endfunction
endpackage

// File: rtl/raifes_uart_if.sv
// rtl/raifes_uart_if.sv - AHB-lite slave port bundle for the UART peripheral
interface raifes_uart_if;
  import raifes_uart_pkg::*;
  logic [HASTI_ADDR_WIDTH-1:0]  haddr;
  logic                         hwrite;
  logic [HASTI_SIZE_WIDTH-1:0]  hsize;
  logic [HASTI_BURST_WIDTH-1:0] hburst;
  logic                         hmastlock;
  logic [HASTI_PROT_WIDTH-1:0]  hprot;
  logic [HASTI_TRANS_WIDTH-1:0] htrans;
  logic [HASTI_BUS_WIDTH-1:0]   hwdata;
  logic [HASTI_BUS_WIDTH-1:0]   hrdata;
  logic                         hready;
  logic [HASTI_RESP_WIDTH-1:0]  hresp;

  modport master (output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
                  input hrdata, hready, hresp);
  modport slave (input haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
                 output hrdata, hready, hresp);
endinterface

// File: rtl/raifes_uart_fifo.sv
// rtl/raifes_uart_fifo.sv - 8-bit synchronous FIFO; push is accepted when full if a pop coincides
module raifes_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [7:0]                 wdata_i,
  input  logic                       pop_i,
  output logic [7:0]                 rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/raifes_uart.sv
// rtl/raifes_uart.sv - memory-mapped 8N1 UART: TX FIFO, single RX holding register, baud divisor
module raifes_uart
  import raifes_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = UART_BASE,
  parameter int          TX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic          clk,
  input  logic          reset,
  raifes_uart_if.slave  bus,
  output logic          txd,
  input  logic          rxd,
  output logic          irq
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic        dsel_q, dwrite_q;
  logic [1:0]  doff_q;
  logic        sel, wr_data, rd_data, wr_status, wr_div;
  logic [15:0] div_q, div_d;

  logic          fifo_full, fifo_empty, tx_pop;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic        txd_q, txd_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_deliver, frame_err_set, overrun_set, tx_drop_set;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d, tx_drop_q, tx_drop_d, frame_err_q, frame_err_d;
  logic        tx_busy;
  logic        unused_ok;

  assign sel       = bus.htrans[1] & ((bus.haddr & 32'hFFFF_FFF0) == BASE_ADDR);
  assign wr_data   = dsel_q & dwrite_q  & (doff_q == UART_DATA);
  assign rd_data   = dsel_q & ~dwrite_q & (doff_q == UART_DATA);
  assign wr_status = dsel_q & dwrite_q  & (doff_q == UART_STATUS);
  assign wr_div    = dsel_q & dwrite_q  & (doff_q == UART_DIV);
  assign unused_ok = ^{bus.hsize, bus.hburst, bus.hmastlock, bus.hprot, bus.htrans[0],
                       bus.hwdata[31:16], fifo_count};

  raifes_uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_data),
    .wdata_i (bus.hwdata[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tx_drop_set = wr_data & fifo_full & ~tx_pop;
  assign tx_busy     = (tx_state_q != S_IDLE) | ~fifo_empty;
  assign div_d       = wr_div ? clamp_div(bus.hwdata[15:0]) : div_q;

  // The same load path serves IDLE and a back-to-back STOP, so frames abut with no idle bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE, S_STOP: begin
        if (tx_state_q == S_STOP && tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end else if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_head;
          tx_cnt_d   = div_q;
          txd_d      = 1'b0;
          tx_state_d = S_START;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      S_START, S_DATA: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end else begin
          tx_cnt_d = div_q;
          if (tx_state_q == S_DATA && tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = (tx_state_q == S_START) ? 3'd0 : tx_bit_q + 3'd1;
            tx_state_d = S_DATA;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // RX counter starts at half a bit so that every later sample lands mid-bit.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_shift_d    = rx_shift_q;
    rx_bit_d      = rx_bit_q;
    rx_cnt_d      = rx_cnt_q;
    rx_deliver    = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q & ~rx_s2_q) begin
          rx_cnt_d   = {1'b0, div_q[15:1]};
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (rx_s2_q) begin
          rx_state_d = S_IDLE;
        end else begin
          rx_cnt_d   = div_q;
          rx_bit_d   = 3'd0;
          rx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = div_q;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_deliver    = rx_s2_q;
          frame_err_set = ~rx_s2_q;
          rx_state_d    = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // A DATA read in the delivery cycle frees the holding register for the new byte.
  always_comb begin
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = rx_valid_q;
    overrun_set = 1'b0;
    if (rx_deliver) begin
      if (!rx_valid_q || rd_data) begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (rd_data) begin
      rx_valid_d = 1'b0;
    end
  end

  assign overrun_d   = overrun_set   | (overrun_q   & ~(wr_status & bus.hwdata[ST_RX_OVERRUN]));
  assign tx_drop_d   = tx_drop_set   | (tx_drop_q   & ~(wr_status & bus.hwdata[ST_TX_DROP]));
  assign frame_err_d = frame_err_set | (frame_err_q & ~(wr_status & bus.hwdata[ST_FRAME_ERR]));

  always_ff @(posedge clk) begin
    if (reset) begin
      dsel_q      <= 1'b0;
      dwrite_q    <= 1'b0;
      doff_q      <= 2'd0;
      div_q       <= DEFAULT_DIV;
      tx_state_q  <= S_IDLE;
      tx_shift_q  <= '0;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      txd_q       <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_shift_q  <= '0;
      rx_bit_q    <= '0;
      rx_cnt_q    <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      tx_drop_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      dsel_q      <= sel;
      dwrite_q    <= bus.hwrite;
      doff_q      <= bus.haddr[3:2];
      div_q       <= div_d;
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_cnt_q    <= tx_cnt_d;
      txd_q       <= txd_d;
      rx_state_q  <= rx_state_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_s1_q     <= rxd;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      tx_drop_q   <= tx_drop_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    bus.hrdata = '0;
    if (dsel_q && !dwrite_q) begin
      case (doff_q)
        UART_DATA:   bus.hrdata = {24'b0, rx_byte_q};
        UART_STATUS: bus.hrdata = {25'b0, frame_err_q, tx_drop_q, overrun_q, rx_valid_q,
                                   tx_busy, fifo_empty, fifo_full};
        UART_DIV:    bus.hrdata = {16'b0, div_q};
        default:     bus.hrdata = '0;
      endcase
    end
  end

  assign bus.hready = 1'b1;
  assign bus.hresp  = '0;
  assign txd        = txd_q;
  assign irq        = rx_valid_q;
endmodule

// File: tb/tb_raifes_uart.sv
// tb/tb_raifes_uart.sv - directed self-checking bench for raifes_uart
module tb_raifes_uart;
  import raifes_uart_pkg::*;

  localparam logic [31:0] A_DATA   = 32'hC000_0000;
  localparam logic [31:0] A_STATUS = 32'hC000_0004;
  localparam logic [31:0] A_DIV    = 32'hC000_0008;
  localparam logic [31:0] A_RSVD   = 32'hC000_000C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic txd, irq;
  int   errors = 0;
  int   checks = 0;

  raifes_uart_if bus();

  raifes_uart dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd),
    .rxd   (rxd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    bus.haddr = a; bus.hwrite = 1'b1; bus.htrans = 2'b10;
    @(negedge clk);
    bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = d;
    @(negedge clk);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    bus.haddr = a; bus.hwrite = 1'b0; bus.htrans = 2'b10;
    @(negedge clk);
    bus.htrans = 2'b00;
    d = bus.hrdata;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (bus.hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected 0", bus.hrdata); end
    checks++; if (bus.hready !== 1'b1 || bus.hresp !== 1'b0) begin errors++; $display("FAIL reset_hready_hresp: got %b/%b expected 1/0", bus.hready, bus.hresp); end
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 00000002", d); end
    ahb_read(A_DIV, d);
    checks++; if (d !== 32'd433) begin errors++; $display("FAIL reset_div: got %0d expected 433", d); end
    ahb_read(A_DATA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", d); end
  endtask

  task automatic test_div_regs();
    logic [31:0] d;
    ahb_write(A_DIV, 32'h0000_0001);
    ahb_read(A_DIV, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL div_clamp: got %0d expected 3", d); end
    ahb_write(A_DIV, 32'hABCD_0010);
    ahb_read(A_DIV, d);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL div_write: got %h expected 00000010", d); end
    ahb_write(A_RSVD, 32'hFFFF_FFFF);
    ahb_read(A_RSVD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h expected 0", d); end
    ahb_write(A_DIV, 32'h0000_0003);
    ahb_read(A_DIV, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL div_three: got %0d expected 3", d); end
  endtask

  task automatic test_tx_byte();
    logic [31:0] d;
    logic [7:0]  b8;
    logic        exp;
    int          n;
    b8 = 8'hA5;
    ahb_write(A_DATA, {24'h0, b8});
    n = 0;
    while (txd !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (txd !== 1'b0) begin
      errors++; $display("FAIL tx_start_timeout: got txd=%b expected 0 within 10 clocks", txd);
      return;
    end
    for (int b = 0; b < 10; b++) begin
      exp = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : b8[b-1];
      checks++; if (txd !== exp) begin errors++; $display("FAIL tx_a5_bit%0d_early: got %b expected %b", b, txd, exp); end
      repeat (3) @(negedge clk);
      checks++; if (txd !== exp) begin errors++; $display("FAIL tx_a5_bit%0d_late: got %b expected %b", b, txd, exp); end
      @(negedge clk);
    end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL tx_idle_after: got %b expected 1", txd); end
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL tx_busy_clear: got %h expected 00000002", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  tx_bytes [6];
    logic        cap [300];
    logic [31:0] st, d;
    logic [7:0]  bv;
    logic        exp, ok;
    int          i0, idx;
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    fork
      begin
        for (int i = 0; i < 300; i++) begin @(negedge clk); cap[i] = txd; end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          bus.haddr = A_DATA; bus.hwrite = 1'b1; bus.htrans = 2'b10;
          if (i > 0) bus.hwdata = {24'h0, tx_bytes[i-1]};
          @(negedge clk);
        end
        bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = {24'h0, tx_bytes[5]};
        @(negedge clk);
        ahb_read(A_STATUS, st);
      end
    join
    checks++; if (st !== 32'h25) begin errors++; $display("FAIL b2b_status_full_drop: got %h expected 00000025", st); end
    i0 = -1;
    for (int i = 0; i < 100; i++) if (i0 < 0 && cap[i] === 1'b0) i0 = i;
    checks++;
    if (i0 < 0) begin
      errors++; $display("FAIL b2b_start_timeout: got no start bit expected one within 100 clocks");
    end else begin
      for (int f = 0; f < 5; f++) begin
        bv = tx_bytes[f];
        for (int b = 0; b < 10; b++) begin
          exp = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bv[b-1];
          ok = 1'b1;
          for (int k = 0; k < 4; k++) begin
            idx = i0 + 40*f + 4*b + k;
            if (cap[idx] !== exp) ok = 1'b0;
          end
          checks++; if (!ok) begin errors++; $display("FAIL b2b_frame%0d_bit%0d: got %b%b%b%b expected %b x4", f, b, cap[i0+40*f+4*b], cap[i0+40*f+4*b+1], cap[i0+40*f+4*b+2], cap[i0+40*f+4*b+3], exp); end
        end
      end
      checks++; if (cap[i0+200] !== 1'b1) begin errors++; $display("FAIL b2b_idle_after: got %b expected 1", cap[i0+200]); end
    end
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL b2b_drop_sticky: got %h expected 00000022", d); end
    ahb_write(A_STATUS, 32'h20);
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL b2b_drop_clear: got %h expected 00000002", d); end
  endtask

  task automatic test_rx_basic();
    logic [31:0] d;
    send_rx(8'h3C, 1'b1);
    repeat (6) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set: got %b expected 1", irq); end
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h0A) begin errors++; $display("FAIL rx_status_valid: got %h expected 0000000a", d); end
    ahb_read(A_DATA, d);
    checks++; if (d !== 32'h3C) begin errors++; $display("FAIL rx_data_3c: got %h expected 0000003c", d); end
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL rx_valid_cleared: got %h expected 00000002", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_cleared: got %b expected 0", irq); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    send_rx(8'h5A, 1'b1);
    send_rx(8'hC3, 1'b1);
    repeat (6) @(negedge clk);
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h1A) begin errors++; $display("FAIL ovr_status: got %h expected 0000001a", d); end
    ahb_read(A_DATA, d);
    checks++; if (d !== 32'h5A) begin errors++; $display("FAIL ovr_keeps_first: got %h expected 0000005a", d); end
    ahb_write(A_STATUS, 32'h10);
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL ovr_clear: got %h expected 00000002", d); end
  endtask

  task automatic test_rx_read_race();
    logic [31:0] d, rd;
    send_rx(8'h81, 1'b1);
    repeat (6) @(negedge clk);
    fork
      send_rx(8'h7E, 1'b1);
      begin
        repeat (39) @(negedge clk);
        bus.haddr = A_DATA; bus.hwrite = 1'b0; bus.htrans = 2'b10;
        @(negedge clk);
        bus.htrans = 2'b00;
        rd = bus.hrdata;
      end
    join
    checks++; if (rd !== 32'h81) begin errors++; $display("FAIL race_old_byte: got %h expected 00000081", rd); end
    repeat (4) @(negedge clk);
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h0A) begin errors++; $display("FAIL race_no_overrun: got %h expected 0000000a", d); end
    ahb_read(A_DATA, d);
    checks++; if (d !== 32'h7E) begin errors++; $display("FAIL race_new_byte: got %h expected 0000007e", d); end
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL race_drained: got %h expected 00000002", d); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] d;
    send_rx(8'h55, 1'b0);
    repeat (6) @(negedge clk);
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h42) begin errors++; $display("FAIL frame_err_status: got %h expected 00000042", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL frame_err_irq: got %b expected 0", irq); end
    ahb_write(A_STATUS, 32'h40);
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL frame_err_clear: got %h expected 00000002", d); end
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (60) @(negedge clk);
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL glitch_status: got %h expected 00000002", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", irq); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    ahb_write(A_DATA, 32'h00);
    repeat (10) @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL midframe_low: got %b expected 0", txd); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midframe_reset_txd: got %b expected 1", txd); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ahb_read(A_STATUS, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL midframe_status: got %h expected 00000002", d); end
    ahb_read(A_DIV, d);
    checks++; if (d !== 32'd433) begin errors++; $display("FAIL midframe_div: got %0d expected 433", d); end
    repeat (8) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midframe_stays_idle: got %b expected 1", txd); end
  endtask

  initial begin
    bus.haddr = '0; bus.hwrite = 1'b0; bus.hsize = 3'd2; bus.hburst = '0;
    bus.hmastlock = 1'b0; bus.hprot = '0; bus.htrans = 2'b00; bus.hwdata = '0;
    @(negedge clk);
    test_reset();
    test_div_regs();
    test_tx_byte();
    test_back_to_back();
    test_rx_basic();
    test_rx_overrun();
    test_rx_read_race();
    test_rx_errors();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
